// File: rtl/lcd_screen_sequencer.sv
// lcd_screen_sequencer: renders one of NUM_SCREENS 2x16 text pages from an
// external character ROM into an HD44780 LCD controller (iDATA/iRS/iStart/oDone
// handshake), substituting a live two-digit decimal value at marker
// characters. Re-renders whenever the page select or value changes, or on
// iRefresh.
module lcd_screen_sequencer #(
  parameter int NUM_SCREENS = 8,
  parameter int SEL_W       = 3,
  parameter int VAL_W       = 7,
  parameter int DLY_CYCLES  = 262142
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [SEL_W-1:0] iScreen,
  input  logic [VAL_W-1:0] iValue,
  input  logic             iRefresh,
  output logic [SEL_W+4:0] oRomAddr,
  input  logic [8:0]       iRomData,
  output logic [7:0]       oLCD_Data,
  output logic             oLCD_RS,
  output logic             oLCD_Start,
  input  logic             iLCD_Done,
  output logic             oBusy
);

  localparam int CNT_W = $clog2(DLY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DLY_CYCLES - 1);
  localparam logic [SEL_W:0]   SCR_LIM  = (SEL_W + 1)'(NUM_SCREENS);
  localparam logic [VAL_W+6:0] SAT_MAX  = (VAL_W + 7)'(99);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_WAITROM, S_SEND, S_HOLD, S_DLY, S_NEXT, S_IDLE, S_CONV
  } state_t;

  state_t           state_q;
  logic [5:0]       idx_q;      // transfer index: 0..3 in init, 0..33 in render
  logic             init_q;     // still running the power-on command list
  logic             load_q;     // first CONV cycle: sample inputs into shadows
  logic             pend_q;     // a re-render has been requested
  logic [SEL_W-1:0] scr_q;      // shadow page being rendered
  logic [6:0]       val_q;      // shadow saturated value
  logic [6:0]       rem_q;      // conversion remainder; holds ones when done
  logic [3:0]       tens_q;
  logic [8:0]       word_q;     // {RS, code} queued for the next SEND
  logic [CNT_W-1:0] cnt_q;

  logic [VAL_W+6:0] val_wide;
  logic [6:0]       val_sat;
  logic             chg;
  logic [5:0]       nxt_idx;
  logic [4:0]       nxt_ci;
  logic             off_page;
  logic [8:0]       rom_word_d;

  // Power-on command list: function set, display on, clear, entry mode.
  function automatic logic [8:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 9'h038;
      2'd1:    return 9'h00C;
      2'd2:    return 9'h001;
      default: return 9'h006;
    endcase
  endfunction

  // Saturated input value, change detection, next ROM char index and
  // digit substitution on the word coming back from the ROM.
  always_comb begin
    val_wide = {7'd0, iValue};
    val_sat  = (val_wide > SAT_MAX) ? 7'd99 : val_wide[6:0];
    chg      = iRefresh | (iScreen != scr_q) | (val_sat != val_q);
    nxt_idx  = idx_q + 6'd1;
    // transfers 1..16 map to chars 0..15, 18..33 to chars 16..31
    nxt_ci   = (nxt_idx <= 6'd16) ? nxt_idx[4:0] - 5'd1 : nxt_idx[4:0] - 5'd2;
    off_page = ({1'b0, scr_q} >= SCR_LIM);
    rom_word_d = iRomData;
    if (iRomData == 9'h1F1)      rom_word_d = {1'b1, 8'h30 + {4'd0, tens_q}};
    else if (iRomData == 9'h1F0) rom_word_d = {1'b1, 8'h30 + {1'b0, rem_q[2:0]} + {rem_q[3], 3'd0}};
  end

  // Sequencer FSM with registered LCD/ROM outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      init_q     <= 1'b1;
      load_q     <= 1'b0;
      pend_q     <= 1'b1;
      scr_q      <= '0;
      val_q      <= '0;
      rem_q      <= '0;
      tens_q     <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      oRomAddr   <= '0;
      oLCD_Data  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_Start <= 1'b0;
      oBusy      <= 1'b1;
    end else begin
      if (chg) pend_q <= 1'b1;
      case (state_q)
        S_INIT: begin
          word_q  <= init_cmd(idx_q[1:0]);
          state_q <= S_SEND;
        end
        S_FETCH: state_q <= S_WAITROM;
        S_WAITROM: begin
          word_q  <= off_page ? 9'h120 : rom_word_d;
          state_q <= S_SEND;
        end
        S_SEND: begin
          oLCD_Data  <= word_q[7:0];
          oLCD_RS    <= word_q[8];
          oLCD_Start <= 1'b1;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (iLCD_Done) begin
            oLCD_Start <= 1'b0;
            state_q    <= S_DLY;
          end
        end
        S_DLY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_NEXT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (init_q) begin
            if (idx_q == 6'd3) begin
              init_q  <= 1'b0;
              idx_q   <= '0;
              load_q  <= 1'b1;
              state_q <= S_CONV;
            end else begin
              idx_q   <= nxt_idx;
              state_q <= S_INIT;
            end
          end else if (idx_q == 6'd33) begin
            // page done: chain straight into a queued re-render without idling
            idx_q <= '0;
            if (pend_q || chg) begin
              load_q  <= 1'b1;
              state_q <= S_CONV;
            end else begin
              oBusy   <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            idx_q <= nxt_idx;
            if (nxt_idx == 6'd17) begin
              word_q  <= 9'h0C0;
              state_q <= S_SEND;
            end else begin
              oRomAddr <= {scr_q, nxt_ci};
              state_q  <= S_FETCH;
            end
          end
        end
        S_IDLE: begin
          if (pend_q) begin
            oBusy   <= 1'b1;
            load_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          if (load_q) begin
            load_q <= 1'b0;
            scr_q  <= iScreen;
            val_q  <= val_sat;
            rem_q  <= val_sat;
            tens_q <= '0;
            pend_q <= 1'b0;
          end else if (rem_q >= 7'd10) begin
            rem_q  <= rem_q - 7'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            idx_q   <= '0;
            word_q  <= 9'h080;
            state_q <= S_SEND;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_screen_sequencer.sv
// Bench for lcd_screen_sequencer: ROM and LCD controller models, a transfer
// recorder, and a page-level reference model of what each render must emit.
module tb_lcd_screen_sequencer;
  localparam int NS = 6, SW = 3, VW = 7, DLY = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic [SW-1:0] iScreen;
  logic [VW-1:0] iValue;
  logic          iRefresh;
  logic [SW+4:0] oRomAddr;
  logic [8:0]    iRomData;
  logic [7:0]    oLCD_Data;
  logic          oLCD_RS, oLCD_Start, iLCD_Done, oBusy;

  logic done_m, spur, served, st_prev;
  int   cnt_m, stall;
  int   checks = 0, errors = 0;
  int   cur_scr, cur_val;
  logic [8:0] rom [0:255];
  logic [8:0] got[$], exp_q[$];

  assign iLCD_Done = done_m | spur;

  lcd_screen_sequencer #(.NUM_SCREENS(NS), .SEL_W(SW), .VAL_W(VW), .DLY_CYCLES(DLY)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iScreen(iScreen), .iValue(iValue), .iRefresh(iRefresh),
    .oRomAddr(oRomAddr), .iRomData(iRomData), .oLCD_Data(oLCD_Data), .oLCD_RS(oLCD_RS),
    .oLCD_Start(oLCD_Start), .iLCD_Done(iLCD_Done), .oBusy(oBusy));

  always #5 iCLK = ~iCLK;

  // synchronous ROM: data one cycle after address
  always @(posedge iCLK) iRomData <= rom[oRomAddr];

  // LCD controller: Done pulse 3 cycles after Start (plus optional stall)
  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      done_m <= 1'b0; served <= 1'b0; cnt_m <= 0;
    end else begin
      done_m <= 1'b0;
      if (!oLCD_Start) begin
        served <= 1'b0; cnt_m <= 0;
      end else if (!served) begin
        if (cnt_m >= 2 + stall) begin done_m <= 1'b1; served <= 1'b1; end
        else cnt_m <= cnt_m + 1;
      end
    end
  end

  // record {RS,data} at each rising Start
  always @(negedge iCLK) begin
    st_prev <= oLCD_Start;
    if (iRST_N && oLCD_Start && !st_prev) got.push_back({oLCD_RS, oLCD_Data});
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001); exp_q.push_back(9'h006);
  endtask

  // expected words for one page render with the value shown as two digits
  task automatic add_render(input int scr, input int val);
    int v, tens, ones;
    v = (val > 99) ? 99 : val;
    tens = v / 10;
    ones = v % 10;
    exp_q.push_back(9'h080);
    for (int k = 0; k < 32; k++) begin
      logic [8:0] w;
      if (k == 16) exp_q.push_back(9'h0C0);
      if (scr >= NS) w = 9'h120;
      else begin
        w = rom[scr * 32 + k];
        if (w == 9'h1F1) w = 9'(9'h130 + tens);
        else if (w == 9'h1F0) w = 9'(9'h130 + ones);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic check_seq(input string tag);
    int n;
    chk({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic wait_render(input string tag);
    int n;
    n = 0;
    while (oBusy !== 1'b1 && n < 50) begin @(negedge iCLK); n++; end
    n = 0;
    while (oBusy !== 1'b0 && n < 8000) begin @(negedge iCLK); n++; end
    chk({tag, "_idle"}, oBusy, 1'b0);
    chk({tag, "_start_low"}, oLCD_Start, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"}, oLCD_Data, 8'h00);
    chk({tag, "_rs"}, oLCD_RS, 1'b0);
    chk({tag, "_start"}, oLCD_Start, 1'b0);
    chk({tag, "_addr"}, oRomAddr, 8'h00);
    chk({tag, "_busy"}, oBusy, 1'b1);
  endtask

  initial begin
    logic [8:0] d0;
    int n;
    iRST_N = 1'b0; iScreen = '0; iValue = '0; iRefresh = 1'b0; spur = 1'b0; stall = 0;
    for (int i = 0; i < 256; i++) rom[i] = {1'b1, 8'(32 + $urandom_range(0, 94))};
    rom[3 * 32 + 25] = 9'h1F1;
    rom[3 * 32 + 26] = 9'h1F0;
    rom[2 * 32 + 3]  = 9'h1F0;
    rom[4 * 32 + 20] = 9'h1F1;
    repeat (3) @(negedge iCLK);
    chk_reset_outs("rst");

    // 1: init + page 0 after reset
    iRST_N = 1'b1;
    add_init(); add_render(0, 0);
    wait_render("t1");
    chk("t1_pulses", got.size(), 38);
    check_seq("t1");

    // 2: placeholders on page 3 with 47
    iScreen = 3; iValue = 47;
    add_render(3, 47);
    wait_render("t2");
    chk("t2_tens", got[27], 9'h134);
    chk("t2_ones", got[28], 9'h137);
    check_seq("t2");

    // 3: saturation to 99
    iValue = 120;
    add_render(3, 120);
    wait_render("t3");
    chk("t3_tens", got[27], 9'h139);
    chk("t3_ones", got[28], 9'h139);
    check_seq("t3");
    cur_scr = 3; cur_val = 120;

    // randomized renders; first one is a pure refresh
    for (int r = 0; r < 5; r++) begin
      int s, v, sv, cv;
      s = (r == 0) ? cur_scr : $urandom_range(0, 7);
      v = (r == 0) ? cur_val : $urandom_range(0, 127);
      sv = (v > 99) ? 99 : v;
      cv = (cur_val > 99) ? 99 : cur_val;
      iScreen = s[SW-1:0]; iValue = v[VW-1:0];
      iRefresh = (s == cur_scr && sv == cv);
      @(negedge iCLK);
      iRefresh = 1'b0;
      add_render(s, v);
      wait_render($sformatf("rnd%0d", r));
      check_seq($sformatf("rnd%0d", r));
      cur_scr = s; cur_val = v;
    end

    // spurious Done while idle is ignored
    spur = 1'b1;
    @(negedge iCLK);
    spur = 1'b0;
    repeat (20) @(negedge iCLK);
    chk("spur_nostart", got.size(), 0);
    chk("spur_busy", oBusy, 1'b0);

    // 4: page changes mid-render collapse into one follow-up render
    iScreen = 1; iRefresh = 1'b1;
    @(negedge iCLK);
    iRefresh = 1'b0;
    n = 0;
    while (oBusy !== 1'b1 && n < 50) begin @(negedge iCLK); n++; end
    repeat (100) @(negedge iCLK);
    iScreen = 2;
    repeat (100) @(negedge iCLK);
    iScreen = 5;
    add_render(1, cur_val); add_render(5, cur_val);
    wait_render("t4");
    check_seq("t4");
    cur_scr = 5;

    // 5: Done withheld for 50 cycles in HOLD
    cur_val = (cur_val == 33) ? 34 : 33;
    stall = 50;
    iValue = cur_val[VW-1:0];
    n = 0;
    while (oLCD_Start !== 1'b1 && n < 100) begin @(negedge iCLK); n++; end
    chk("t5_start", oLCD_Start, 1'b1);
    d0 = {oLCD_RS, oLCD_Data};
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      chk($sformatf("t5_hold%0d", i), {oLCD_Start, oLCD_RS, oLCD_Data}, {1'b1, d0});
    end
    chk("t5_onepulse", got.size(), 1);
    stall = 0;
    add_render(5, cur_val);
    wait_render("t5");
    check_seq("t5");

    // 6: reset during DLY, then off-range page renders as spaces
    iScreen = 4;
    n = 0;
    while (oLCD_Start !== 1'b1 && n < 200) begin @(negedge iCLK); n++; end
    n = 0;
    while (oLCD_Start !== 1'b0 && n < 200) begin @(negedge iCLK); n++; end
    chk("t6_in_dly", oLCD_Start, 1'b0);
    iRST_N = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    @(negedge iCLK);
    got.delete(); exp_q.delete();
    iScreen = 7;
    @(negedge iCLK);
    iRST_N = 1'b1;
    add_init(); add_render(7, cur_val);
    wait_render("t6");
    chk("t6_space", got[10], 9'h120);
    check_seq("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
